pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register; generic successor to the fixed-width decode/execute latch.
- Carries an opaque payload of DATA_W bits with a valid/ready handshake, stall and flush.
- Adds a programmable post-flush squash count that discards the next N upstream transfers. This generalises the single-slot branch-shadow kill.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM).

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_skid_buf.sv | 38 +++
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline registers.
//   - Per-stage NOP payload constants (what a bubble looks like downstream).
//   - kill_cnt_t: squash counter type for the default KILL_W of 2.
//   - Stall-vector bit indices; the hazard unit ORs selected bits into stall_i.
package pipe_pkg;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_KILL_W = 2;

  typedef logic [PIPE_KILL_W-1:0] kill_cnt_t;

  // RISC-V canonical NOP (addi x0,x0,0) in the instruction slot; zero elsewhere.
  localparam logic [PIPE_DATA_W-1:0] IF_ID_NOP  = {96'h0, 32'h0000_0013};
  localparam logic [PIPE_DATA_W-1:0] ID_EX_NOP  = {PIPE_DATA_W{1'b0}};
  localparam logic [PIPE_DATA_W-1:0] EX_MEM_NOP = {PIPE_DATA_W{1'b0}};

  // Stall vector bit positions.
  localparam int STALL_LOAD_USE   = 0;
  localparam int STALL_MUL_BUSY   = 1;
  localparam int STALL_DCACHE_MISS = 2;
  localparam int STALL_VEC_W      = 3;

  function automatic logic any_stall(input logic [STALL_VEC_W-1:0] v);
    return |v;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry skid register.
//   clk, rst       : clock, synchronous active-high reset
//   clr            : drop the entry (flush)
//   load/load_data : capture a payload into the entry
//   pop            : entry moved downstream this cycle
//   skid_valid/skid_data : entry state
// Priority: rst > clr > load > pop. The parent never loads and pops in the same
// cycle because it deasserts in_ready while the entry is full.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              pop,
  input  logic [DATA_W-1:0] load_data,
  output logic              skid_valid,
  output logic [DATA_W-1:0] skid_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (clr) begin
      skid_valid <= 1'b0;
    end else if (load) begin
      skid_valid <= 1'b1;
      skid_data  <= load_data;
    end else if (pop) begin
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready
// handshake, stall, flush and a post-flush squash counter.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//                                  (out_data = NOP_PAYLOAD while a bubble)
//   stall_i         : hazard hold, blocks upstream intake only
//   flush_i         : kill held contents and load squash count
//   flush_skip_i    : number of later accepted transfers to discard
//   kill_pending_o  : squash counter nonzero (from the counter flop)
//
// Build option: define PIPE_SKID_EN to add a one-entry skid buffer; in_ready
// then depends only on stall_i and the skid flop, cutting the out_ready ->
// in_ready combinational path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 128,
  parameter int                 KILL_W      = 2,
  parameter logic [DATA_W-1:0]  NOP_PAYLOAD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [KILL_W-1:0] flush_skip_i,
  output logic              kill_pending_o
);

  logic [KILL_W-1:0] kill_cnt, kill_n;
  logic              out_valid_n;
  logic [DATA_W-1:0] out_data_n;
  logic              accepted, drain;

  assign accepted       = in_valid & in_ready;
  assign drain          = out_valid & out_ready;
  assign kill_pending_o = (kill_cnt != '0);

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load, skid_pop;

  assign in_ready = !rst & !stall_i & !skid_valid;

  pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush_i),
    .load       (skid_load),
    .pop        (skid_pop),
    .load_data  (in_data),
    .skid_valid (skid_valid),
    .skid_data  (skid_data)
  );
`else
  assign in_ready = !rst & !stall_i & (!out_valid | out_ready);
`endif

  always_comb begin
    out_valid_n = out_valid;
    out_data_n  = out_data;
    kill_n      = kill_cnt;
`ifdef PIPE_SKID_EN
    skid_load   = 1'b0;
    skid_pop    = 1'b0;
`endif
    if (flush_i) begin
      // Any same-cycle accept is discarded and does not consume the count.
      out_valid_n = 1'b0;
      out_data_n  = NOP_PAYLOAD;
      kill_n      = flush_skip_i;
    end else if (accepted && kill_cnt != '0) begin
      // Squashed transfer: drop payload, old contents follow normal drain/hold.
      kill_n = kill_cnt - KILL_W'(1);
      if (drain) begin
        out_valid_n = 1'b0;
        out_data_n  = NOP_PAYLOAD;
      end
    end else if (accepted) begin
`ifdef PIPE_SKID_EN
      // Accept implies skid empty; park it if out is held.
      if (out_valid && !out_ready) begin
        skid_load = 1'b1;
      end else begin
        out_valid_n = 1'b1;
        out_data_n  = in_data;
      end
`else
      out_valid_n = 1'b1;
      out_data_n  = in_data;
`endif
    end else if (drain) begin
`ifdef PIPE_SKID_EN
      if (skid_valid) begin
        skid_pop    = 1'b1;
        out_valid_n = 1'b1;
        out_data_n  = skid_data;
      end else begin
        out_valid_n = 1'b0;
        out_data_n  = NOP_PAYLOAD;
      end
`else
      out_valid_n = 1'b0;
      out_data_n  = NOP_PAYLOAD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= NOP_PAYLOAD;
      kill_cnt  <= '0;
    end else begin
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      kill_cnt  <= kill_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DATA_W = 128;
  localparam int KILL_W = 2;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, out_valid, out_ready;
  logic              stall_i, flush_i, kill_pending_o;
  logic [DATA_W-1:0] in_data, out_data;
  logic [KILL_W-1:0] flush_skip_i;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .KILL_W(KILL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_i(stall_i), .flush_i(flush_i), .flush_skip_i(flush_skip_i),
    .kill_pending_o(kill_pending_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_data = 128'h99; out_ready = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0; flush_skip_i = '0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tick; tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_checks++; if (kill_pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_kill: got %b expected 0", kill_pending_o); end
    rst = 1'b0; in_valid = 1'b0;
    tick;
  endtask

  task automatic test_stream;
    logic [DATA_W-1:0] exp;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = DATA_W'(i);
      in_valid = 1'b1; in_data = exp;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
      tick;
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL stream_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp); end
    end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin n_fail++; $display("FAIL stream_end: got v=%b d=%h expected v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_hold;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'hA;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifndef PIPE_SKID_EN
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
`endif
      n_checks++; if (out_valid !== 1'b1 || out_data !== 128'hA) begin n_fail++; $display("FAIL hold_data[%0d]: got v=%b d=%h expected v=1 d=a", i, out_valid, out_data); end
      tick;
    end
    out_ready = 1'b1;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_consumed_once: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_flush_skip;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'hB;
    tick;
    in_valid = 1'b0; flush_i = 1'b1; flush_skip_i = 2'd2;
    tick;
    flush_i = 1'b0; flush_skip_i = '0; out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin n_fail++; $display("FAIL flush_kill_b: got v=%b d=%h expected v=0 d=0", out_valid, out_data); end
    n_checks++; if (kill_pending_o !== 1'b1) begin n_fail++; $display("FAIL flush_pending_set: got %b expected 1", kill_pending_o); end
    // Idle cycle: count must not move without an accepted transfer.
    tick;
    n_checks++; if (kill_pending_o !== 1'b1) begin n_fail++; $display("FAIL flush_pending_idle: got %b expected 1", kill_pending_o); end
    in_valid = 1'b1; in_data = 128'hC;
    tick;
    n_checks++; if (out_valid !== 1'b0 || kill_pending_o !== 1'b1) begin n_fail++; $display("FAIL squash_c: got v=%b kp=%b expected v=0 kp=1", out_valid, kill_pending_o); end
    in_data = 128'hD;
    tick;
    n_checks++; if (out_valid !== 1'b0 || kill_pending_o !== 1'b0) begin n_fail++; $display("FAIL squash_d: got v=%b kp=%b expected v=0 kp=0", out_valid, kill_pending_o); end
    in_data = 128'hE;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 128'hE) begin n_fail++; $display("FAIL pass_e: got v=%b d=%h expected v=1 d=e", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_flush_overwrite;
    // A second flush replaces the residual count rather than adding to it.
    flush_i = 1'b1; flush_skip_i = 2'd3;
    tick;
    flush_skip_i = 2'd1;
    tick;
    flush_i = 1'b0; flush_skip_i = '0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 128'h21;
    tick;
    n_checks++; if (out_valid !== 1'b0 || kill_pending_o !== 1'b0) begin n_fail++; $display("FAIL overwrite_squash: got v=%b kp=%b expected v=0 kp=0", out_valid, kill_pending_o); end
    in_data = 128'h22;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 128'h22) begin n_fail++; $display("FAIL overwrite_pass: got v=%b d=%h expected v=1 d=22", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_flush_accept;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 128'hF; flush_i = 1'b1; flush_skip_i = '0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_acc_ready: got %b expected 1", in_ready); end
    tick;
    flush_i = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 128'h0 || kill_pending_o !== 1'b0) begin n_fail++; $display("FAIL flush_acc_drop: got v=%b d=%h kp=%b expected v=0 d=0 kp=0", out_valid, out_data, kill_pending_o); end
    in_data = 128'h11;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 128'h11) begin n_fail++; $display("FAIL flush_acc_next: got v=%b d=%h expected v=1 d=11", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_stall;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 128'h5;
    tick;
    in_data = 128'h6; stall_i = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready0: got %b expected 0", in_ready); end
    tick;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin n_fail++; $display("FAIL stall_bubble: got v=%b d=%h expected v=0 d=0", out_valid, out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready1: got %b expected 0", in_ready); end
    tick;
    stall_i = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b expected 1", in_ready); end
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 128'h6) begin n_fail++; $display("FAIL stall_accept6: got v=%b d=%h expected v=1 d=6", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
  endtask

`ifdef PIPE_SKID_EN
  task automatic test_skid;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h7;
    tick;
    in_data = 128'h8;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_empty: got %b expected 1", in_ready); end
    tick;
    in_data = 128'h9;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_ready_full: got %b expected 0", in_ready); end
    n_checks++; if (out_data !== 128'h7) begin n_fail++; $display("FAIL skid_hold7: got %h expected 7", out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 128'h8) begin n_fail++; $display("FAIL skid_order8: got v=%b d=%h expected v=1 d=8", out_valid, out_data); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty: got v=%b expected 0", out_valid); end
    // Reset mid-stream with both entries full.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h7;
    tick;
    in_data = 128'h8;
    tick;
    in_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0; out_ready = 1'b1;
    tick;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_rst_clear: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_hold;
    test_flush_skip;
    test_flush_overwrite;
    test_flush_accept;
    test_stall;
`ifdef PIPE_SKID_EN
    test_skid;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
